mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported, multi-cycle main memory between the I-cache miss handler and the D-cache miss/write-through handler.
- Grants one requester at a time and sequences a full block fill, or a single-word write, onto the memory port.
- Returns fill words to the granted requester tagged with their word index.
- Sits between the two cache controllers and the main memory model, replacing the direct memory hookups of the single-cycle core.

Parameters:
- ADDR_W, 16, address width in bits
- DATA_W, 16, word width in bits
- WORDS_PER_BLK, 8, words per cache block (16-byte block, 2-byte words)
- MEM_LAT, 4, cycles from read issue to mem_rvalid

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-cache fill request; held high until i_done
- i_addr  in  ADDR_W  I-side miss address
- i_grant  out  1  I-side owns the memory port
- i_valid  out  1  fill_data is a valid I-side word
- i_done  out  1  one-cycle pulse: I-side transfer complete
- d_req  in  1  D-side request; held high until d_done
- d_wr  in  1  1 = single-word write, 0 = block fill
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  D-side write data
- d_grant  out  1  D-side owns the memory port
- d_valid  out  1  fill_data is a valid D-side word
- d_done  out  1  one-cycle pulse: D-side transfer complete
- fill_data  out  DATA_W  returned memory word (shared)
- fill_idx  out  3  word index within the block for fill_data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  write when mem_en
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: all outputs 0; state IDLE; issue and return counters cleared. Reset mid-transfer aborts it with no done pulse. mem_rvalid arriving after reset is ignored while in IDLE.
- States: IDLE, FILL, WRITE.
- IDLE: samples requests.
  - d_req wins over i_req (fixed priority; see optional feature).
  - Winner's grant rises the next cycle, together with the first memory access.
- FILL:
  - Base address = addr with bits [3:0] cleared.
  - Issues WORDS_PER_BLK reads on consecutive cycles: mem_en=1, mem_wr=0, mem_addr = base + 2k for k = 0..7.
  - Return counter increments on each mem_rvalid. fill_data = mem_rdata and fill_idx = return count, with the granted side's *_valid asserted the same cycle (combinational pass-through).
  - *_done is asserted with the 8th returned word. Next state IDLE; grant drops on the following cycle.
  - Fill latency: first word arrives MEM_LAT cycles after grant; done at grant + MEM_LAT + 7.
- WRITE (d_wr=1 only):
  - One cycle of mem_en=1, mem_wr=1, mem_addr = d_addr with bit 0 cleared, mem_wdata = d_wdata.
  - d_done pulses the next cycle, then IDLE.
  - An I-side request never writes.
- Grant is stable for the whole transfer.
- Requester inputs are captured at grant. Changes, or dropping req, mid-transfer are ignored; the transfer always completes.
- At most one grant is high at any time. Grant-to-grant gap is at least 1 IDLE cycle.
- mem_rvalid outside FILL is ignored (no valid, no counter change).
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. A one-bit last-winner register is cleared on reset to "I last". When both requests are high in IDLE, the side that did not win last is granted.
- Undefined: fixed D-over-I priority; no last-winner register.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding constants IDLE/FILL/WRITE
  - Side encoding SIDE_I/SIDE_D
  - Block offset mask 16'hFFF0
- One natural sub-module, arb_pick: combinational requester selection. It takes d_req, i_req and the last winner, and outputs the winning side, so the priority/round-robin choice lives in one place.

Test Plan:
- I fill alone: i_req=1, i_addr=16'h1236 → mem_addr 16'h1230, 16'h1232 … 16'h123E on 8 consecutive cycles. i_valid with fill_idx 0..7. i_done with word 7, at grant + 11 cycles.
- D write: d_req=1, d_wr=1, d_addr=16'h4001, d_wdata=16'hBEEF → one cycle of mem_en=1, mem_wr=1, mem_addr=16'h4000, mem_wdata=16'hBEEF. d_done the next cycle. No d_valid.
- Simultaneous requests: d_req (fill, 16'h0040) and i_req (16'h0080) rise the same cycle → D granted first. I granted 1 cycle after d_done. With MEM_ARB_RR_EN and a prior D win, I goes first.
- Requester misbehaviour: i_addr changed and i_req dropped in the middle of a fill → addresses stay on the original block and all 8 words are still returned with i_done.
- Reset mid-fill: rst asserted after 3 returned words → next cycle all outputs 0, state IDLE. No done pulse. Stray mem_rvalid afterwards produces no *_valid.
- Wrap: i_addr=16'hFFF8 → addresses 16'hFFF0 … 16'hFFFE, with no carry into other blocks.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, requester sides, block mask.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    // Clears the byte offset within a 16-byte block.
    localparam logic [15:0] BLK_MASK = 16'hFFF0;

    // Complement of the block mask: the in-block byte offset bits.
    localparam logic [15:0] BLK_OFS = ~BLK_MASK;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Requester selection: picks I or D side from the live requests (MEM_ARB_RR_EN = round-robin).
// Latency: combinational.
// Backpressure: none; the caller only consults the pick while idle.
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  side_e last_win,
`endif
    input  logic  d_req,
    input  logic  i_req,
    output side_e win
);

    // Choose the winning side; with no request the result is don't-care (I).
    always_comb begin
        win = SIDE_I;
`ifdef MEM_ARB_RR_EN
        if (d_req && i_req) begin
            win = (last_win == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_req) begin
            win = SIDE_D;
        end
`else
        if (d_req) begin
            win = SIDE_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between I-cache fills and D-cache fills/writes (MEM_ARB_RR_EN = round-robin).
// Latency: grant + first access 1 cycle after request; fill done at grant+MEM_LAT+7; write done at grant+1.
// Backpressure: requesters hold req until their done pulse; the losing side simply waits in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int MEM_LAT       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_valid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_valid,
    output logic              d_done,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_idx,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    // MEM_LAT only shapes the memory's timing; the FSM just counts returns.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BLK_OFS);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);
    localparam logic [3:0]        N_WORDS   = 4'(WORDS_PER_BLK);
    localparam logic [2:0]        LAST_IDX  = 3'(WORDS_PER_BLK - 1);

    state_e            state;
    side_e             grant_side;
    side_e             pick;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] pick_addr;
    logic [3:0]        issue_cnt;
    logic [2:0]        ret_cnt;
    logic              wr_done;
    logic              fill_fire;
    logic              last_word;

`ifdef MEM_ARB_RR_EN
    side_e             last_win;

    arb_pick u_pick (
        .last_win (last_win),
        .d_req    (d_req),
        .i_req    (i_req),
        .win      (pick)
    );
`else
    arb_pick u_pick (
        .d_req    (d_req),
        .i_req    (i_req),
        .win      (pick)
    );
`endif

    assign pick_addr = (pick == SIDE_D) ? d_addr : i_addr;

    // Returned words pass straight through to the granted side; only accepted in FILL.
    assign fill_fire = (state == FILL) && mem_rvalid;
    assign last_word = (ret_cnt == LAST_IDX);
    assign i_valid   = fill_fire && (grant_side == SIDE_I);
    assign d_valid   = fill_fire && (grant_side == SIDE_D);
    assign i_done    = i_valid && last_word;
    assign d_done    = (d_valid && last_word) || wr_done;
    assign fill_data = fill_fire ? mem_rdata : '0;
    assign fill_idx  = fill_fire ? ret_cnt : '0;

    // Arbitration FSM: captures the winner's request at grant and sequences the memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_side <= SIDE_I;
            i_grant    <= 1'b0;
            d_grant    <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            base       <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            wr_done    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_win   <= SIDE_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_en    <= 1'b0;
                    mem_wr    <= 1'b0;
                    wr_done   <= 1'b0;
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                    if (i_req || d_req) begin
                        grant_side <= pick;
                        i_grant    <= (pick == SIDE_I);
                        d_grant    <= (pick == SIDE_D);
`ifdef MEM_ARB_RR_EN
                        last_win   <= pick;
`endif
                        mem_en     <= 1'b1;
                        if (pick == SIDE_D && d_wr) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_addr  <= d_addr & WORD_MASK;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= FILL;
                            base      <= pick_addr & ADDR_MASK;
                            mem_addr  <= pick_addr & ADDR_MASK;
                            issue_cnt <= 4'd1;
                        end
                    end
                end

                FILL: begin
                    // Issue side: one read per cycle until the whole block is requested.
                    if (issue_cnt < N_WORDS) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= base + ADDR_W'({issue_cnt[2:0], 1'b0});
                        issue_cnt <= issue_cnt + 4'd1;
                    end else begin
                        mem_en    <= 1'b0;
                    end
                    // Return side: the last word ends the transfer and releases the grant.
                    if (mem_rvalid) begin
                        if (last_word) begin
                            state     <= IDLE;
                            i_grant   <= 1'b0;
                            d_grant   <= 1'b0;
                            mem_en    <= 1'b0;
                            issue_cnt <= '0;
                            ret_cnt   <= '0;
                        end else begin
                            ret_cnt   <= ret_cnt + 3'd1;
                        end
                    end
                end

                WRITE: begin
                    // First cycle carries the write strobe; second cycle signals completion.
                    if (mem_en) begin
                        mem_en  <= 1'b0;
                        mem_wr  <= 1'b0;
                        wr_done <= 1'b1;
                    end else begin
                        wr_done <= 1'b0;
                        d_grant <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    i_grant <= 1'b0;
                    d_grant <= 1'b0;
                    mem_en  <= 1'b0;
                    mem_wr  <= 1'b0;
                    wr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model (data = addr ^ 16'h5A5A).
// Latency: memory returns each read 4 cycles after its issue cycle.
// Backpressure: requesters hold req until done, as real cache controllers would.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_grant;
    logic        i_valid;
    logic        i_done;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_grant;
    logic        d_valid;
    logic        d_done;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        stray_rv;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_grant    (i_grant),
        .i_valid    (i_valid),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_grant    (d_grant),
        .d_valid    (d_valid),
        .d_done     (d_done),
        .fill_data  (fill_data),
        .fill_idx   (fill_idx),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 4-deep read pipeline, returned data derived from the address.
    logic [3:0]  pv;
    logic [15:0] pa0, pa1, pa2, pa3;
    always @(posedge clk) begin
        pv  <= {pv[2:0], mem_en & ~mem_wr};
        pa0 <= mem_addr;
        pa1 <= pa0;
        pa2 <= pa1;
        pa3 <= pa2;
    end
    assign mem_rvalid = pv[3] | stray_rv;
    assign mem_rdata  = pa3 ^ 16'h5A5A;

    // Per-transfer observations collected by watch().
    int          obs_grant_cyc;
    int          obs_done_cyc;
    int          obs_done_idx;
    int          obs_n_iss;
    int          obs_n_ret;
    int          obs_cross;
    logic [15:0] obs_addr [0:15];
    logic [15:0] obs_data [0:7];
    logic [2:0]  obs_idx  [0:7];

    // Observe one transfer for the given side; optionally misbehave or stop early.
    task automatic watch(input bit dside, input int budget, input int mutate_at, input int stop_after);
        obs_grant_cyc = -1;
        obs_done_cyc  = -1;
        obs_done_idx  = -1;
        obs_n_iss     = 0;
        obs_n_ret     = 0;
        obs_cross     = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if ((dside ? d_grant : i_grant) && obs_grant_cyc < 0) obs_grant_cyc = c;
            if ((i_grant && d_grant) || (dside ? (i_valid || i_done) : (d_valid || d_done))) obs_cross++;
            if (!dside && d_grant) obs_cross++;
            if (mem_en && !mem_wr) begin
                if (obs_n_iss < 16) obs_addr[obs_n_iss] = mem_addr;
                obs_n_iss++;
            end
            if (dside ? d_valid : i_valid) begin
                if (obs_n_ret < 8) begin
                    obs_data[obs_n_ret] = fill_data;
                    obs_idx[obs_n_ret]  = fill_idx;
                end
                obs_n_ret++;
            end
            if (c == mutate_at) begin
                i_addr = 16'h7770;
                i_req  = 1'b0;
            end
            if (dside ? d_done : i_done) begin
                obs_done_cyc = c;
                obs_done_idx = int'(fill_idx);
                if (dside) d_req = 1'b0;
                else       i_req = 1'b0;
                break;
            end
            if (stop_after > 0 && obs_n_ret == stop_after) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; stray_rv = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if ({i_grant, d_grant} !== 2'b00) begin n_fail++; $display("FAIL reset_grants: got %b want 00", {i_grant, d_grant}); end
        n_checks++; if ({i_valid, d_valid, i_done, d_done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {i_valid, d_valid, i_done, d_done}); end
        n_checks++; if ({mem_en, mem_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_en, mem_wr}); end
        n_checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
        n_checks++; if ({fill_data, fill_idx} !== 19'h0) begin n_fail++; $display("FAIL reset_fill: got %h want 0", {fill_data, fill_idx}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_d_write();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h4001; d_wdata = 16'hBEEF;
        @(negedge clk);
        n_checks++; if ({d_grant, i_grant} !== 2'b10) begin n_fail++; $display("FAIL wr_grant: got %b want 10", {d_grant, i_grant}); end
        n_checks++; if ({mem_en, mem_wr} !== 2'b11) begin n_fail++; $display("FAIL wr_strobe: got %b want 11", {mem_en, mem_wr}); end
        n_checks++; if (mem_addr !== 16'h4000) begin n_fail++; $display("FAIL wr_addr: got %h want 4000", mem_addr); end
        n_checks++; if (mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_data: got %h want beef", mem_wdata); end
        n_checks++; if ({d_done, d_valid} !== 2'b00) begin n_fail++; $display("FAIL wr_early_done: got %b want 00", {d_done, d_valid}); end
        @(negedge clk);
        n_checks++; if ({d_done, d_valid, mem_en} !== 3'b100) begin n_fail++; $display("FAIL wr_done: got %b want 100", {d_done, d_valid, mem_en}); end
        d_req = 1'b0; d_wr = 1'b0; d_wdata = 16'h1111;
        @(negedge clk);
        n_checks++; if ({d_grant, d_done} !== 2'b00) begin n_fail++; $display("FAIL wr_release: got %b want 00", {d_grant, d_done}); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_i_fill();
        i_req = 1'b1; i_addr = 16'h1236;
        watch(1'b0, 40, 0, 0);
        n_checks++; if (obs_grant_cyc !== 1) begin n_fail++; $display("FAIL ifill_grant_cyc: got %0d want 1", obs_grant_cyc); end
        n_checks++; if (obs_n_iss !== 8) begin n_fail++; $display("FAIL ifill_issues: got %0d want 8", obs_n_iss); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (obs_addr[k] !== 16'h1230 + 16'(2 * k)) begin n_fail++; $display("FAIL ifill_addr[%0d]: got %h want %h", k, obs_addr[k], 16'h1230 + 16'(2 * k)); end
            n_checks++; if (obs_idx[k] !== 3'(k)) begin n_fail++; $display("FAIL ifill_idx[%0d]: got %0d want %0d", k, obs_idx[k], k); end
            n_checks++; if (obs_data[k] !== ((16'h1230 + 16'(2 * k)) ^ 16'h5A5A)) begin n_fail++; $display("FAIL ifill_data[%0d]: got %h want %h", k, obs_data[k], (16'h1230 + 16'(2 * k)) ^ 16'h5A5A); end
        end
        n_checks++; if (obs_n_ret !== 8) begin n_fail++; $display("FAIL ifill_returns: got %0d want 8", obs_n_ret); end
        n_checks++; if (obs_done_cyc - obs_grant_cyc !== 11) begin n_fail++; $display("FAIL ifill_done_lat: got %0d want 11", obs_done_cyc - obs_grant_cyc); end
        n_checks++; if (obs_done_idx !== 7) begin n_fail++; $display("FAIL ifill_done_idx: got %0d want 7", obs_done_idx); end
        n_checks++; if (obs_cross !== 0) begin n_fail++; $display("FAIL ifill_cross: got %0d want 0", obs_cross); end
        @(negedge clk);
        n_checks++; if ({i_grant, mem_en, i_done} !== 3'b000) begin n_fail++; $display("FAIL ifill_release: got %b want 000", {i_grant, mem_en, i_done}); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        i_req = 1'b1; i_addr = 16'h0080;
        watch(1'b1, 40, 0, 0);
        n_checks++; if (obs_grant_cyc !== 1) begin n_fail++; $display("FAIL sim_d_grant_cyc: got %0d want 1", obs_grant_cyc); end
        n_checks++; if (obs_cross !== 0) begin n_fail++; $display("FAIL sim_d_cross: got %0d want 0", obs_cross); end
        n_checks++; if (obs_addr[0] !== 16'h0040 || obs_addr[7] !== 16'h004E) begin n_fail++; $display("FAIL sim_d_addr: got %h..%h want 0040..004e", obs_addr[0], obs_addr[7]); end
        n_checks++; if (obs_n_ret !== 8 || obs_done_cyc !== 12) begin n_fail++; $display("FAIL sim_d_done: got %0d words at cyc %0d want 8 at 12", obs_n_ret, obs_done_cyc); end
        watch(1'b0, 40, 0, 0);
        n_checks++; if (obs_grant_cyc !== 2) begin n_fail++; $display("FAIL sim_i_grant_gap: got %0d want 2", obs_grant_cyc); end
        n_checks++; if (obs_addr[0] !== 16'h0080 || obs_addr[7] !== 16'h008E) begin n_fail++; $display("FAIL sim_i_addr: got %h..%h want 0080..008e", obs_addr[0], obs_addr[7]); end
        n_checks++; if (obs_done_cyc - obs_grant_cyc !== 11) begin n_fail++; $display("FAIL sim_i_done_lat: got %0d want 11", obs_done_cyc - obs_grant_cyc); end
        repeat (2) @(negedge clk);
    endtask

`ifdef MEM_ARB_RR_EN
    task automatic test_round_robin();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h0001;
        repeat (2) @(negedge clk);
        d_req = 1'b0; d_wr = 1'b0;
        repeat (2) @(negedge clk);
        d_req = 1'b1; d_addr = 16'h0200;
        i_req = 1'b1; i_addr = 16'h0300;
        watch(1'b0, 40, 0, 0);
        n_checks++; if (obs_grant_cyc !== 1) begin n_fail++; $display("FAIL rr_i_first: got %0d want 1", obs_grant_cyc); end
        n_checks++; if (obs_addr[0] !== 16'h0300) begin n_fail++; $display("FAIL rr_i_addr: got %h want 0300", obs_addr[0]); end
        watch(1'b1, 40, 0, 0);
        n_checks++; if (obs_grant_cyc !== 2) begin n_fail++; $display("FAIL rr_d_second: got %0d want 2", obs_grant_cyc); end
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_misbehave();
        i_req = 1'b1; i_addr = 16'h2346;
        watch(1'b0, 40, 3, 0);
        n_checks++; if (obs_n_iss !== 8) begin n_fail++; $display("FAIL misb_issues: got %0d want 8", obs_n_iss); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (obs_addr[k] !== 16'h2340 + 16'(2 * k)) begin n_fail++; $display("FAIL misb_addr[%0d]: got %h want %h", k, obs_addr[k], 16'h2340 + 16'(2 * k)); end
        end
        n_checks++; if (obs_n_ret !== 8 || obs_done_cyc !== 12) begin n_fail++; $display("FAIL misb_done: got %0d words at cyc %0d want 8 at 12", obs_n_ret, obs_done_cyc); end
        n_checks++; if (obs_grant_cyc !== 1) begin n_fail++; $display("FAIL misb_grant: got %0d want 1", obs_grant_cyc); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int n_bad;
        i_req = 1'b1; i_addr = 16'h0500;
        watch(1'b0, 40, 0, 3);
        n_checks++; if (obs_n_ret !== 3 || obs_done_cyc !== -1) begin n_fail++; $display("FAIL rmid_pre: got %0d words done %0d want 3 words no done", obs_n_ret, obs_done_cyc); end
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({i_grant, d_grant, mem_en, mem_wr} !== 4'b0) begin n_fail++; $display("FAIL rmid_ctl: got %b want 0000", {i_grant, d_grant, mem_en, mem_wr}); end
        n_checks++; if ({i_valid, d_valid, i_done, d_done} !== 4'b0) begin n_fail++; $display("FAIL rmid_flags: got %b want 0000", {i_valid, d_valid, i_done, d_done}); end
        n_checks++; if ({mem_addr, mem_wdata, fill_data, fill_idx} !== 51'h0) begin n_fail++; $display("FAIL rmid_bus: got %h want 0", {mem_addr, mem_wdata, fill_data, fill_idx}); end
        rst = 1'b0;
        n_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (i_valid || d_valid || i_done || d_done || i_grant || d_grant) n_bad++;
            stray_rv = (c == 6);
        end
        @(negedge clk);
        if (i_valid || d_valid || i_done || d_done) n_bad++;
        stray_rv = 1'b0;
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL rmid_stray: got %0d bad cycles want 0", n_bad); end
    endtask

    task automatic test_wrap();
        i_req = 1'b1; i_addr = 16'hFFF8;
        watch(1'b0, 40, 0, 0);
        n_checks++; if (obs_grant_cyc !== 1) begin n_fail++; $display("FAIL wrap_grant: got %0d want 1", obs_grant_cyc); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (obs_addr[k] !== 16'hFFF0 + 16'(2 * k)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, obs_addr[k], 16'hFFF0 + 16'(2 * k)); end
        end
        n_checks++; if (obs_idx[0] !== 3'd0 || obs_n_ret !== 8) begin n_fail++; $display("FAIL wrap_returns: got idx0 %0d n %0d want 0 and 8", obs_idx[0], obs_n_ret); end
        n_checks++; if (obs_done_cyc !== 12) begin n_fail++; $display("FAIL wrap_done: got %0d want 12", obs_done_cyc); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_d_write();
        test_i_fill();
        test_simultaneous();
`ifdef MEM_ARB_RR_EN
        test_round_robin();
`endif
        test_misbehave();
        test_reset_mid_fill();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
